// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART frame transmitter and its gap timer.
// Contents: framer state encoding, byte width, counter-width helper.
package uart_frame_tx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Bits needed to hold 0..max_count, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count < 2) return 1;
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Word-source and UART-side signals of the frame transmitter.
// master: the framer (consumes data_in/data_valid/tx_done_tick, drives the rest).
// slave : the surrounding system (word source plus UART transmitter).
//   data_in      word to transmit, BYTE_W*BYTES bits
//   data_valid   request to send data_in
//   tx_done_tick UART transmitter finished the current byte
//   ready        framer idle, data_valid accepted
//   tx_start     one-cycle load pulse for the UART transmitter
//   tx_data      byte being transmitted
//   busy         framer not idle
//   frame_done   one-cycle pulse after the last byte of a frame
interface uart_frame_tx_if #(
  parameter int unsigned BYTES = 3
);
  import uart_frame_tx_pkg::*;

  logic [BYTE_W*BYTES-1:0] data_in;
  logic                    data_valid;
  logic                    tx_done_tick;
  logic                    ready;
  logic                    tx_start;
  logic [BYTE_W-1:0]       tx_data;
  logic                    busy;
  logic                    frame_done;

  modport master (
    input  data_in, data_valid, tx_done_tick,
    output ready, tx_start, tx_data, busy, frame_done
  );

  modport slave (
    output data_in, data_valid, tx_done_tick,
    input  ready, tx_start, tx_data, busy, frame_done
  );

endinterface

// File: rtl/uart_frame_tx_gap_timer.sv
// Idle-gap timer: cleared on load, counts while enabled, flags the last cycle.
//   clk, rst  clock and synchronous active-high reset
//   clear     restart the count from zero
//   en        count this cycle
//   done_c    combinational: enabled and this is cycle CYCLES of the count
module uart_frame_tx_gap_timer
  import uart_frame_tx_pkg::*;
#(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = cnt_width(CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count value CYCLES-1 marks the final cycle, giving CYCLES counted cycles.
  always_comb begin
    cnt_d  = cnt_q;
    done_c = en && (cnt_q == CNT_W'(CYCLES - 1));
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Splits a BYTES-wide word into bytes, MSB first, and hands them one at a
// time to a UART transmitter, then holds off for GAP_CYCLES idle cycles.
//   clk, rst  clock and synchronous active-high reset
//   bus       uart_frame_tx_if master: word handshake and UART byte handshake
// Parameters: BYTES per frame, GAP_CYCLES idle after a frame (0 = none),
// ONLY_ON_CHANGE suppresses resending the previously sent word.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int unsigned BYTES          = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter bit          ONLY_ON_CHANGE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_tx_if.master bus
);

  localparam int unsigned WORD_W = BYTE_W * BYTES;
  localparam int unsigned BCNT_W = cnt_width(BYTES - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   last_sent_q, last_sent_d;
  logic                last_valid_q, last_valid_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                frame_done_q, frame_done_d;

  logic gap_clear_c;
  logic gap_en_c;
  logic gap_done_c;
  logic skip_c;
  logic last_byte_c;

  uart_frame_tx_gap_timer #(
    .CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (gap_clear_c),
    .en     (gap_en_c),
    .done_c (gap_done_c)
  );

  // Next-state and registered-output logic.
  // tx_start/tx_data are set on the transition into START so the pulse is
  // visible during the START cycle itself.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    last_sent_d  = last_sent_q;
    last_valid_d = last_valid_q;
    byte_cnt_d   = byte_cnt_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    gap_clear_c  = 1'b0;
    gap_en_c     = 1'b0;

    skip_c      = ONLY_ON_CHANGE && last_valid_q && (bus.data_in == last_sent_q);
    last_byte_c = (byte_cnt_q == BCNT_W'(BYTES - 1));

    unique case (state_q)
      ST_IDLE: begin
        // A skipped word is consumed without leaving IDLE.
        if (bus.data_valid && !skip_c) begin
          shift_d      = bus.data_in;
          last_sent_d  = bus.data_in;
          last_valid_d = 1'b1;
          byte_cnt_d   = '0;
          tx_start_d   = 1'b1;
          tx_data_d    = bus.data_in[WORD_W-1 -: BYTE_W];
          state_d      = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_done_tick) begin
          if (!last_byte_c) begin
            shift_d    = shift_q << BYTE_W;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            tx_start_d = 1'b1;
            tx_data_d  = shift_d[WORD_W-1 -: BYTE_W];
            state_d    = ST_START;
          end else begin
            frame_done_d = 1'b1;
            gap_clear_c  = 1'b1;
            state_d      = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_en_c = 1'b1;
        if (gap_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      last_sent_q  <= '0;
      last_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      last_sent_q  <= last_sent_d;
      last_valid_q <= last_valid_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit-side framer that feeds the UART transmitter on the sending board.
- Accepts one 24-bit position/data word and emits it as 3 bytes, MSB first, one UART transfer per byte.
- Each byte transfer is handshaked on the transmitter's done tick, and frames are separated by a programmable idle gap.
- The receiving board's byte-to-word assembler reconstructs the word in the same MSB-first order.

Parameters:
- BYTES, 3, bytes per frame; word width is 8*BYTES.
- GAP_CYCLES, 1000, clk cycles of enforced idle after the last byte's done tick. 0 means no gap.
- ONLY_ON_CHANGE, 1, when 1, a word equal to the last transmitted word is accepted but not sent.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  8*BYTES  word to transmit; sampled only on accept.
- data_valid  in  1  request to send data_in.
- tx_done_tick  in  1  one-cycle pulse from the UART transmitter: current byte finished.
- ready  out  1  high in IDLE; data_valid is accepted only when ready=1.
- tx_start  out  1  one-cycle pulse: UART transmitter loads tx_data.
- tx_data  out  8  byte being transmitted.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on completion of the last byte of a frame.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs: tx_start=0, tx_data=8'h00, busy=0, frame_done=0, ready=1.
  - Internal: shift register=0, byte counter=0, gap counter=0, last_sent=0, last_valid=0.
- State machine: IDLE -> START -> WAIT -> (START | GAP) -> IDLE.
- IDLE:
  - If data_valid=1 and ready=1, compute skip = ONLY_ON_CHANGE && last_valid && (data_in == last_sent).
  - skip=1: word is consumed, no bytes are sent, state stays IDLE.
  - skip=0: latch data_in into the shift register and into last_sent, set last_valid=1, clear byte_cnt, next state START.
- START (exactly one cycle):
  - tx_start=1.
  - tx_data = top byte of the shift register. The first tx_start occurs one cycle after accept.
  - Next state WAIT.
- WAIT:
  - tx_start=0; tx_data is held stable.
  - On tx_done_tick=1 with byte_cnt < BYTES-1: shift register left by 8, byte_cnt+1, next state START.
  - On tx_done_tick=1 with byte_cnt = BYTES-1: frame_done=1 for that one cycle, gap counter cleared, next state GAP. If GAP_CYCLES=0, next state is IDLE instead.
- GAP:
  - Counter increments every cycle.
  - Exit to IDLE on the cycle the counter reaches GAP_CYCLES-1, so exactly GAP_CYCLES cycles are spent in GAP.
- Registered outputs: tx_start, tx_data, frame_done. Combinational outputs: ready = (state==IDLE), busy = ~ready.
- Counter widths: gap counter $clog2(GAP_CYCLES+1), minimum 1 bit. byte counter $clog2(BYTES), minimum 1 bit. No wrap-around is possible because both counters are compared and cleared.
- Boundary conditions:
  - data_valid while busy: ignored; no queue. The word is lost unless the source holds it.
  - tx_done_tick outside WAIT: ignored; no state change.
  - tx_done_tick in the same cycle as entering WAIT: not possible, because WAIT is entered after START. A tick in the START cycle is ignored.
  - Zero bytes: transmitted unmodified; no escaping or substitution.
  - rst mid-frame: partial frame is abandoned, tx_start is low from the next cycle, last_valid=0. The next accepted word is therefore always sent.
  - data_in changing after accept: no effect; the latched copy is used.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, START, WAIT, GAP);
  - constant BYTE_W=8;
  - a function computing the counter width from GAP_CYCLES.
- Natural sub-module: frame_gap_timer (load/clear, count, done pulse), which is reusable by the receive-side timeout logic.
- The rest stays in one module.

Test Plan:
- Reset, then data_in=24'h12A4C7 with one data_valid pulse, and a UART model returning tx_done_tick 10 cycles after each tx_start -> tx_data sequence 8'h12, 8'h A4, 8'h C7 with three tx_start pulses; frame_done on the third tick; busy for 3*(1+10)+GAP_CYCLES cycles.
- Same word sent twice with ONLY_ON_CHANGE=1 -> second accept gives zero tx_start pulses and ready stays 1. Then 24'h12A4C8 -> full 3-byte frame.
- data_valid asserted every cycle during a frame with a different data_in each cycle -> no disturbance to the bytes in flight; the first word accepted after GAP is the data_in present on the first IDLE cycle.
- Spurious tx_done_tick in IDLE and in START -> no state change, no extra bytes.
- rst raised while waiting for the 2nd byte's done tick -> next cycle: tx_start=0, tx_data=0, ready=1. Re-sending the previous word produces a full frame (last_valid cleared).
- GAP_CYCLES=0 and data_in=24'h000000 -> bytes 00,00,00 are sent; ready returns in the cycle after the third tick; back-to-back frames have no idle cycles.
